// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding and width defaults for the SRAM data-memory controller.
// Imported by sram_controller; no logic lives here.
package sram_ctrl_pkg;

    localparam int DEF_SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W     = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_controller.sv
// Splits a 32-bit load/store into two 16-bit async-SRAM accesses; ready returns 2*ACCESS_CYCLES+1
// cycles after a request appears. The pipeline is frozen (ready=0) for the whole access.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int SRAM_ADDR_W   = DEF_SRAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic                     op_wr;
    logic [SRAM_ADDR_W-2:0]   word_idx;
    logic [SRAM_DATA_W-1:0]   low_half;

    logic                     req;
    logic                     last;
    logic                     wr_nxt;
    logic [SRAM_ADDR_W-2:0]   idx_nxt;
    logic                     unused_addr_bits;

    assign req  = wr_en | rd_en;
    assign last = (cnt == CNT_LAST);

    // Op and index come from the inputs only on the starting edge; afterwards the latched copies rule.
    assign wr_nxt  = (state == S_IDLE) ? wr_en : op_wr;
    assign idx_nxt = (state == S_IDLE) ? address[SRAM_ADDR_W:2] : word_idx;

    assign unused_addr_bits = ^{address[31:SRAM_ADDR_W+1], address[1:0]};

    assign ready = (state == S_DONE) | ((state == S_IDLE) & ~wr_en & ~rd_en);

    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req)  state_nxt = S_LOW;
            S_LOW:  if (last) state_nxt = S_HIGH;
            S_HIGH: if (last) state_nxt = S_DONE;
            S_DONE:           state_nxt = S_IDLE;
            default:          state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            word_idx    <= '0;
            low_half    <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            state <= state_nxt;

            if ((state_nxt != state) || (state == S_IDLE) || (state == S_DONE))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if ((state == S_IDLE) && req) begin
                op_wr    <= wr_en;
                word_idx <= address[SRAM_ADDR_W:2];
            end

            if ((state == S_LOW) && last && !op_wr)
                low_half <= sram_dq_in;

            if ((state == S_HIGH) && last && !op_wr)
                read_data <= {sram_dq_in, low_half};

            // Pins are registered from the next state so they line up with the state they belong to.
            case (state_nxt)
                S_LOW: begin
                    sram_addr   <= {idx_nxt, 1'b0};
                    sram_dq_out <= write_data[15:0];
                    sram_we_n   <= ~wr_nxt;
                    sram_oe_n   <= wr_nxt;
                    sram_dq_oe  <= wr_nxt;
                end
                S_HIGH: begin
                    sram_addr   <= {idx_nxt, 1'b1};
                    sram_dq_out <= write_data[31:16];
                    sram_we_n   <= ~wr_nxt;
                    sram_oe_n   <= wr_nxt;
                    sram_dq_oe  <= wr_nxt;
                end
                default: begin
                    sram_we_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with behavioural async SRAMs and a read-data scoreboard.
module tb_sram_controller;
    import sram_ctrl_pkg::*;

    logic clk;
    logic rst;

    // Instance 0: ACCESS_CYCLES = 2
    logic        wr_en0, rd_en0, ready0;
    logic [31:0] address0, write_data0, read_data0;
    logic [17:0] addr0;
    logic [15:0] dq_out0, dq_in0;
    logic        dq_oe0, we_n0, oe_n0, ce_n0, ub_n0, lb_n0;

    // Instance 1: ACCESS_CYCLES = 1
    logic        wr_en1, rd_en1, ready1;
    logic [31:0] address1, write_data1, read_data1;
    logic [17:0] addr1;
    logic [15:0] dq_out1, dq_in1;
    logic        dq_oe1, we_n1, oe_n1, ce_n1, ub_n1, lb_n1;

    sram_controller #(.ACCESS_CYCLES(2), .SRAM_ADDR_W(18)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
        .write_data(write_data0), .read_data(read_data0), .ready(ready0),
        .sram_addr(addr0), .sram_dq_out(dq_out0), .sram_dq_oe(dq_oe0), .sram_dq_in(dq_in0),
        .sram_we_n(we_n0), .sram_oe_n(oe_n0), .sram_ce_n(ce_n0), .sram_ub_n(ub_n0), .sram_lb_n(lb_n0)
    );

    sram_controller #(.ACCESS_CYCLES(1), .SRAM_ADDR_W(18)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
        .write_data(write_data1), .read_data(read_data1), .ready(ready1),
        .sram_addr(addr1), .sram_dq_out(dq_out1), .sram_dq_oe(dq_oe1), .sram_dq_in(dq_in1),
        .sram_we_n(we_n1), .sram_oe_n(oe_n1), .sram_ce_n(ce_n1), .sram_ub_n(ub_n1), .sram_lb_n(lb_n1)
    );

    // Behavioural asynchronous SRAMs: combinational read, write while we_n is low.
    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];

    assign dq_in0 = !oe_n0 ? mem0[addr0[7:0]] : 16'h0000;
    assign dq_in1 = !oe_n1 ? mem1[addr1[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!we_n0 && dq_oe0) mem0[addr0[7:0]] <= dq_out0;
        if (!we_n1 && dq_oe1) mem1[addr1[7:0]] <= dq_out1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [0:63];
    logic [31:0] last_rd = 32'h0;
    int          lat;
    int          we_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives one request on u0 and follows it to the ready cycle.
    task automatic run(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input bit withdraw, input int exp_lat, input string tag);
        wr_en0 = w; rd_en0 = r; address0 = a; write_data0 = d;
        if (w) begin
            ref_mem[a[7:2]] = d;
            exp_q.push_back(last_rd);
        end else begin
            last_rd = ref_mem[a[7:2]];
            exp_q.push_back(last_rd);
        end
        lat = -1;
        we_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (withdraw && k == 1) begin
                wr_en0 = 1'b0; rd_en0 = 1'b0;
            end
            #1;
            if (we_n0 == 1'b0) we_cnt++;
            if (ready0) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (exp_q.size() != 0)
            check({tag, "_read_data"}, read_data0, exp_q.pop_front());
    endtask

    task automatic idle_inputs0;
        wr_en0 = 1'b0; rd_en0 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        mem1[8] = 16'h1111;
        mem1[9] = 16'h2222;

        rst = 1'b1;
        wr_en0 = 0; rd_en0 = 0; address0 = 0; write_data0 = 0;
        wr_en1 = 0; rd_en1 = 0; address1 = 0; write_data1 = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", ready0, 1);
        check("rst_we_n", we_n0, 1);
        check("rst_oe_n", oe_n0, 1);
        check("rst_dq_oe", dq_oe0, 0);
        check("rst_read_data", read_data0, 32'h0);
        check("rst_sram_addr", addr0, 0);
        check("rst_dq_out", dq_out0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single write, then read back.
        run(1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 5, "wr1");
        check("wr1_we_n_low_cycles", we_cnt, 4);
        @(negedge clk);
        idle_inputs0();
        check("wr1_hw8", mem0[8], 16'hBEEF);
        check("wr1_hw9", mem0[9], 16'hDEAD);

        run(0, 1, 32'h0000_0010, 32'h0, 0, 5, "rd1");
        @(negedge clk);
        idle_inputs0();
        repeat (3) @(negedge clk);
        #1;
        check("rd1_hold", read_data0, 32'hDEAD_BEEF);

        // Back-to-back write then read of the same word.
        @(negedge clk);
        run(1, 0, 32'h0000_0020, 32'h1234_5678, 0, 5, "b2b_wr");
        @(negedge clk);
        run(0, 1, 32'h0000_0020, 32'h0, 0, 5, "b2b_rd");
        @(negedge clk);
        idle_inputs0();

        // Both enables high: store wins, read_data untouched.
        @(negedge clk);
        run(1, 1, 32'h0000_0040, 32'hA5A5_5A5A, 0, 5, "both");
        @(negedge clk);
        idle_inputs0();
        check("both_hw20", mem0[8'h20], 16'h5A5A);
        check("both_hw21", mem0[8'h21], 16'hA5A5);

        // Request withdrawn after the first cycle still completes.
        @(negedge clk);
        run(0, 1, 32'h0000_0010, 32'h0, 1, 5, "withdraw");
        @(negedge clk);
        idle_inputs0();

        // Reset during the HIGH phase of a write.
        @(negedge clk);
        wr_en0 = 1'b1; address0 = 32'h0000_0030; write_data0 = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        #1;
        check("rstmid_in_high_we_n", we_n0, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid_we_n", we_n0, 1);
        check("rstmid_dq_oe", dq_oe0, 0);
        check("rstmid_oe_n", oe_n0, 1);
        check("rstmid_read_data", read_data0, 32'h0);
        check("rstmid_ready_req", ready0, 0);
        rst = 1'b0;
        idle_inputs0();
        last_rd = 32'h0;
        #1;
        check("rstmid_ready_idle", ready1 & ready0, 1);

        // ACCESS_CYCLES = 1, unaligned address bits ignored.
        @(negedge clk);
        rd_en1 = 1'b1; address1 = 32'h0000_0013;
        exp_q.push_back({mem1[9], mem1[8]} ^ 32'h0 | 32'h2222_1111);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (k == 1) check("ac1_addr_low", addr1, 18'd8);
            if (k == 2) check("ac1_addr_high", addr1, 18'd9);
            if (ready1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("ac1_latency", lat, 3);
        check("ac1_read_data", read_data1, exp_q.pop_front());
        @(negedge clk);
        rd_en1 = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
